// File: rtl/subsurf_sched_if.sv
// rtl/subsurf_sched_if.sv - shared RAM port bundle (RAM0..RAM2) driven by the scheduler
interface subsurf_sched_if #(
   parameter int ADDR_WIDTH = 11
);
   logic [2:0]              en;
   logic [3*ADDR_WIDTH-1:0] a;
   logic [11:0]             we;
   logic [95:0]             di;
   logic [31:0]             do2;

   modport master (output en, a, we, di, input do2);
   modport slave  (input en, a, we, di, output do2);
endinterface

// File: rtl/subsurf_sched.sv
// rtl/subsurf_sched.sv - multi-pass scheduler around subsurf; copies RAM2 results back into RAM0
// Optional busy-cycle counter enabled by SUBSURF_SCHED_PERF_EN.
module subsurf_sched #(
   parameter int ADDR_WIDTH = 11,
   parameter int PASS_W     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [PASS_W-1:0]       passes_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [PASS_W-1:0]       pass_idx_o,
   output logic                    overflow_o,
   output logic [31:0]             perf_cycles_o,
   output logic                    eng_start_o,
   input  logic                    eng_busy_i,
   input  logic [31:0]             eng_word_count_i,
   input  logic [2:0]              eng_en_i,
   input  logic [3*ADDR_WIDTH-1:0] eng_a_i,
   input  logic [11:0]             eng_we_i,
   input  logic [95:0]             eng_di_i,
   subsurf_sched_if.master         ram
);
   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_ARM, S_WAIT, S_CHECK, S_COPY, S_DONE
   } state_t;

   localparam logic [32:0]         WC_MAX  = 33'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] RD_ONE  = 1;
   localparam logic [PASS_W-1:0]   PASS_ONE = 1;

   state_t                state_q;
   logic                  busy_q, done_q, eng_start_q, overflow_q;
   logic [PASS_W-1:0]     npass_q, pass_idx_q;
   logic [ADDR_WIDTH:0]   wc_q, rd_addr_q;
   logic                  wr_valid_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic                  start_ok;
   logic                  rd_active;

   assign start_ok  = start_i && !eng_busy_i;
   assign rd_active = (state_q == S_COPY) && (rd_addr_q < wc_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         eng_start_q <= 1'b0;
         overflow_q  <= 1'b0;
         npass_q     <= '0;
         pass_idx_q  <= '0;
         wc_q        <= '0;
         rd_addr_q   <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
      end else begin
         done_q      <= 1'b0;
         eng_start_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  npass_q    <= passes_i;
                  pass_idx_q <= '0;
                  overflow_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (passes_i == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= S_LAUNCH;
                     eng_start_q <= 1'b1;
                  end
               end
            end
            S_LAUNCH: state_q <= S_ARM;
            // engine busy lags its start by a cycle, so ARM never looks at it
            S_ARM:    state_q <= S_WAIT;
            S_WAIT: begin
               if (!eng_busy_i) state_q <= S_CHECK;
            end
            S_CHECK: begin
               wc_q      <= eng_word_count_i[ADDR_WIDTH:0];
               rd_addr_q <= '0;
               if ({1'b0, eng_word_count_i} > WC_MAX) begin
                  overflow_q <= 1'b1;
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
               end else if (pass_idx_q == npass_q - PASS_ONE) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_COPY;
               end
            end
            S_COPY: begin
               wr_valid_q <= rd_active;
               wr_addr_q  <= rd_addr_q[ADDR_WIDTH-1:0];
               // the final write drains in the same cycle the read side finds itself done
               if (rd_active) begin
                  rd_addr_q <= rd_addr_q + RD_ONE;
               end else begin
                  pass_idx_q  <= pass_idx_q + PASS_ONE;
                  state_q     <= S_LAUNCH;
                  eng_start_q <= 1'b1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ram.en = '0;
      ram.a  = '0;
      ram.we = '0;
      ram.di = '0;
      case (state_q)
         S_LAUNCH, S_ARM, S_WAIT: begin
            ram.en = eng_en_i;
            ram.a  = eng_a_i;
            ram.we = eng_we_i;
            ram.di = eng_di_i;
         end
         S_COPY: begin
            if (rd_active) begin
               ram.en[2]                          = 1'b1;
               ram.a[2*ADDR_WIDTH +: ADDR_WIDTH]  = rd_addr_q[ADDR_WIDTH-1:0];
            end
            if (wr_valid_q) begin
               ram.en[0]                = 1'b1;
               ram.we[3:0]              = 4'hF;
               ram.a[ADDR_WIDTH-1:0]    = wr_addr_q;
               ram.di[31:0]             = ram.do2;
            end
         end
         default: ;
      endcase
   end

`ifdef SUBSURF_SCHED_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE && start_ok) perf_d = '0;
      else if (busy_q && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   assign perf_cycles_o = perf_q;
`else
   assign perf_cycles_o = 32'd0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_idx_o  = pass_idx_q;
   assign overflow_o  = overflow_q;
   assign eng_start_o = eng_start_q;
endmodule

// File: tb/tb_subsurf_sched.sv
// tb/tb_subsurf_sched.sv - directed bench for subsurf_sched with engine and RAM models
module tb_subsurf_sched;
   localparam int AW = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic [2:0]    passes = '0;
   logic          busy, done, overflow, eng_start;
   logic [2:0]    pass_idx;
   logic [31:0]   perf;
   logic          eng_busy;
   logic [31:0]   eng_wc;
   logic [2:0]    eng_en;
   logic [3*AW-1:0] eng_a;
   logic [11:0]   eng_we;
   logic [95:0]   eng_di;

   subsurf_sched_if #(.ADDR_WIDTH(AW)) ram_if ();

   subsurf_sched #(.ADDR_WIDTH(AW), .PASS_W(3)) dut (
      .clk(clk), .rst(rst), .start_i(start), .passes_i(passes),
      .busy_o(busy), .done_o(done), .pass_idx_o(pass_idx), .overflow_o(overflow),
      .perf_cycles_o(perf), .eng_start_o(eng_start), .eng_busy_i(eng_busy),
      .eng_word_count_i(eng_wc), .eng_en_i(eng_en), .eng_a_i(eng_a),
      .eng_we_i(eng_we), .eng_di_i(eng_di), .ram(ram_if)
   );

   // engine model: busy for eng_len cycles after eng_start, writing RAM2[k] = {A0+pass, k}
   int          eng_len = 20;
   int          wc_tab [0:3];
   int          eng_cnt = 0;
   int          eng_n = 0;
   int          eng_p = 0;
   logic [31:0] eng_wc_q = '0;

   always @(posedge clk) begin
      if (start) eng_n <= 0;
      if (eng_start) begin
         eng_cnt  <= eng_len;
         eng_p    <= eng_n;
         eng_n    <= eng_n + 1;
         eng_wc_q <= 32'(wc_tab[eng_n & 3]);
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
      end
   end

   assign eng_busy = (eng_cnt != 0);
   assign eng_wc   = eng_wc_q;

   always_comb begin
      if (eng_busy) begin
         eng_en = 3'b100;
         eng_we = 12'hF00;
         eng_a  = {AW'(eng_len - eng_cnt), 22'h0};
         eng_di = {8'hA0 + 8'(eng_p), 24'(eng_len - eng_cnt), 64'h0};
      end else begin
         eng_en = 3'b010;
         eng_we = 12'h0F0;
         eng_a  = '1;
         eng_di = {3{32'hDEAD_BEEF}};
      end
   end

   logic [31:0] ram0 [0:2047];
   logic [31:0] ram2 [0:2047];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2048; i++) begin
            ram2[i] <= {8'h55, 24'(i)};
            ram0[i] <= 32'h0;
         end
      end else begin
         if (ram_if.en[2]) begin
            if (ram_if.we[11:8] != 4'h0) ram2[ram_if.a[2*AW +: AW]] <= ram_if.di[95:64];
            ram_if.do2 <= ram2[ram_if.a[2*AW +: AW]];
         end
         if (ram_if.en[0] && ram_if.we[3:0] == 4'hF) ram0[ram_if.a[AW-1:0]] <= ram_if.di[31:0];
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int p, input int k);
      return (k < eng_len) ? {8'hA0 + 8'(p), 24'(k)} : {8'h55, 24'(k)};
   endfunction

   int es [0:7];
   int bf [0:7];
   int n_es, n_bf, n_busy, n_wr, n_rd, done_c, max_pidx;

   task automatic do_reset();
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input logic [2:0] np, input int budget);
      logic          prev_rd_v;
      logic [AW-1:0] prev_rd_a;
      logic          prev_eb;
      n_es = 0; n_bf = 0; n_busy = 0; n_wr = 0; n_rd = 0; done_c = -1; max_pidx = 0;
      prev_rd_v = 1'b0; prev_rd_a = '0; prev_eb = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      passes = np;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (eng_start) begin
            if (n_es < 8) es[n_es] = k;
            n_es++;
         end
         if (!eng_busy && prev_eb) begin
            if (n_bf < 8) bf[n_bf] = k;
            n_bf++;
         end
         prev_eb = eng_busy;
         if (busy) n_busy++;
         if (int'(pass_idx) > max_pidx) max_pidx = int'(pass_idx);
         if (ram_if.en[0] && ram_if.we[3:0] != 4'h0) begin
            n_wr++;
            check("wr_after_rd", 32'(prev_rd_v), 32'd1);
            check("wr_addr", 32'(ram_if.a[AW-1:0]), 32'(prev_rd_a));
            check("wr_data", ram_if.di[31:0], exp_word(int'(pass_idx), int'(ram_if.a[AW-1:0])));
         end
         prev_rd_v = ram_if.en[2] && ram_if.we[11:8] == 4'h0;
         prev_rd_a = ram_if.a[2*AW +: AW];
         if (prev_rd_v) n_rd++;
         if (done) begin
            done_c = k;
            break;
         end
      end
      check("done_seen", 32'(done_c >= 0), 32'd1);
   endtask

   initial begin
      wc_tab = '{0, 0, 0, 0};
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_eng_start", 32'(eng_start), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_pass_idx", 32'(pass_idx), 0);
      check("rst_perf", perf, 0);
      check("rst_en", 32'(ram_if.en), 0);
      check("rst_we", 32'(ram_if.we), 0);
      check("rst_a", 32'(ram_if.a), 0);
      check("rst_di", 32'(ram_if.di != 96'h0), 0);
      rst = 1'b0;

      // single pass: no copy, done two cycles after engine busy falls
      eng_len = 20; wc_tab = '{50, 0, 0, 0};
      run(3'd1, 200);
      check("p1_starts", 32'(n_es), 1);
      check("p1_first_start", 32'(es[0]), 1);
      check("p1_writes", 32'(n_wr), 0);
      check("p1_reads", 32'(n_rd), 0);
      check("p1_done_cyc", 32'(done_c), 24);
      check("p1_done_vs_fall", 32'(done_c - bf[0]), 2);
      check("p1_pass_idx", 32'(max_pidx), 0);
      @(negedge clk);
      check("p1_busy_after", 32'(busy), 0);
      check("p1_done_pulse", 32'(done), 0);

      // three passes with wc 8 then 26
      do_reset();
      eng_len = 20; wc_tab = '{8, 26, 5, 0};
      run(3'd3, 400);
      check("p3_starts", 32'(n_es), 3);
      check("p3_start1", 32'(es[1]), 33);
      check("p3_start2", 32'(es[2]), 83);
      check("p3_gap1", 32'(es[1] - bf[0]), 11);
      check("p3_gap2", 32'(es[2] - bf[1]), 29);
      check("p3_done_cyc", 32'(done_c), 106);
      check("p3_writes", 32'(n_wr), 34);
      check("p3_reads", 32'(n_rd), 34);
      check("p3_pass_idx", 32'(max_pidx), 2);
      check("p3_ram0_0", ram0[0], 32'hA100_0000);
      check("p3_ram0_19", ram0[19], 32'hA100_0013);
      check("p3_ram0_25", ram0[25], 32'h5500_0019);
      check("p3_ram0_26", ram0[26], 32'h0);

      // zero passes
      do_reset();
      run(3'd0, 20);
      check("p0_done_cyc", 32'(done_c), 1);
      check("p0_busy_cycles", 32'(n_busy), 1);
      check("p0_starts", 32'(n_es), 0);
      @(negedge clk);
      check("p0_busy_after", 32'(busy), 0);

      // overflow, then cleared by the next accepted start
      do_reset();
      eng_len = 20; wc_tab = '{2049, 4, 0, 0};
      run(3'd2, 200);
      check("ov_flag", 32'(overflow), 1);
      check("ov_done_cyc", 32'(done_c), 24);
      check("ov_starts", 32'(n_es), 1);
      check("ov_writes", 32'(n_wr), 0);
      check("ov_reads", 32'(n_rd), 0);
      repeat (3) @(negedge clk);
      check("ov_sticky", 32'(overflow), 1);
      eng_len = 5; wc_tab = '{3, 0, 0, 0};
      run(3'd1, 100);
      check("ov_cleared", 32'(overflow), 0);

      // largest legal word count
      do_reset();
      eng_len = 20; wc_tab = '{2048, 1, 0, 0};
      run(3'd2, 3000);
      check("wcmax_overflow", 32'(overflow), 0);
      check("wcmax_writes", 32'(n_wr), 2048);
      check("wcmax_gap", 32'(es[1] - bf[0]), 2051);
      check("wcmax_ram0_last", ram0[2047], 32'h5500_07FF);

      // zero word count: copy stage lasts one cycle
      do_reset();
      eng_len = 20; wc_tab = '{0, 0, 0, 0};
      run(3'd2, 200);
      check("wc0_writes", 32'(n_wr), 0);
      check("wc0_reads", 32'(n_rd), 0);
      check("wc0_gap", 32'(es[1] - bf[0]), 3);
      check("wc0_starts", 32'(n_es), 2);

      // reset while copying
      do_reset();
      eng_len = 20; wc_tab = '{26, 0, 0, 0};
      @(negedge clk);
      start = 1'b1; passes = 3'd2;
      @(posedge clk);
      #1 start = 1'b0;
      begin
         bit found = 1'b0;
         for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (ram_if.en[2] && ram_if.we[11:8] == 4'h0) found = 1'b1;
         end
         check("rc_copy_seen", 32'(found), 1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rc_en", 32'(ram_if.en), 0);
      check("rc_we", 32'(ram_if.we), 0);
      check("rc_a", 32'(ram_if.a), 0);
      check("rc_di", 32'(ram_if.di != 96'h0), 0);
      check("rc_busy", 32'(busy), 0);

      // reset while engine busy; start is held off until eng_busy falls
      do_reset();
      eng_len = 20; wc_tab = '{2, 0, 0, 0};
      @(negedge clk);
      start = 1'b1; passes = 3'd1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1;
      passes = 3'd1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rw_busy_blocked", 32'(busy), 0);
         check("rw_no_eng_start", 32'(eng_start), 0);
         check("rw_en_dropped", 32'(ram_if.en), 0);
      end
      begin
         bit fell = 1'b0;
         for (int k = 0; k < 100 && !fell; k++) begin
            @(negedge clk);
            if (!eng_busy) fell = 1'b1;
         end
         check("rw_eng_idle", 32'(fell), 1);
      end
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("rw_accepted", 32'(eng_start), 1);
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
         end
         check("rw_done", 32'(seen), 1);
      end

      // perf counter
      do_reset();
      eng_len = 10; wc_tab = '{4, 4, 0, 0};
      run(3'd2, 200);
      check("pf_done_cyc", 32'(done_c), 32);
      check("pf_busy_cycles", 32'(n_busy), 32);
      @(negedge clk);
`ifdef SUBSURF_SCHED_PERF_EN
      check("pf_count", perf, 32'd32);
      check("pf_vs_board", perf, 32'(n_busy));
      repeat (3) @(negedge clk);
      check("pf_hold", perf, 32'd32);
`else
      check("pf_off", perf, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
